// File: rtl/adder_pkg.sv
// Shared definitions for the digit-serial add/subtract unit.
//   state_e      : controller states (IDLE / RUN / DONE)
//   cnt_width()  : digit-counter width for a given WIDTH/DIGIT, never below 1
//   geometry_ok(): legal WIDTH/DIGIT pairing (DIGIT divides WIDTH, 1 <= DIGIT <= WIDTH)
package adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic int cnt_width(input int width, input int digit);
        int n;
        if (digit < 1) return 1;
        n = width / digit;
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic bit geometry_ok(input int width, input int digit);
        return (digit >= 1) && (digit <= width) && ((width % digit) == 0);
    endfunction

endpackage

// File: rtl/rca_digit.sv
// One DIGIT-bit slice of a ripple-carry adder (purely combinational).
//   a, b   : digit operands
//   cin    : carry into bit 0
//   sum    : digit result
//   cout   : carry out of the top bit
//   c_msb  : carry into the top bit, used for signed-overflow detection
module rca_digit #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] sum,
    output logic             cout,
    output logic             c_msb
);

    // Carry kept as a block-local variable so the chain is a straight
    // sequence of assignments rather than a self-referencing vector.
    always_comb begin
        logic carry;
        carry = cin;
        sum   = '0;
        c_msb = cin;
        for (int i = 0; i < DIGIT; i++) begin
            if (i == DIGIT - 1) c_msb = carry;
            sum[i] = a[i] ^ b[i] ^ carry;
            carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        cout = carry;
    end

endmodule

// File: rtl/digit_serial_adder.sv
// Multi-cycle add/subtract unit: processes WIDTH-bit operands DIGIT bits per
// cycle, least-significant digit first, with a registered inter-digit carry.
//   clk, rst_n          : clock, async active-low reset
//   in_valid/in_ready   : operand handshake (a, b, cin, sub sampled on accept)
//   sub                 : 0 -> a + b + cin, 1 -> a - b - cin
//   flush               : synchronous abort back to IDLE
//   out_valid/out_ready : result handshake
//   sum, cout, ovf      : result, final carry (sub: 1 = no borrow), signed overflow
//   busy                : operation in flight (RUN or DONE)
//
// state   | meaning
// --------+---------------------------------------------------------
// ST_IDLE | waiting for operands, in_ready=1
// ST_RUN  | one digit per cycle through rca_digit, N cycles
// ST_DONE | result presented, held until out_ready
module digit_serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int              N    = WIDTH / DIGIT;
    localparam int              CW   = cnt_width(WIDTH, DIGIT);
    localparam logic [CW-1:0]   LAST = CW'(N - 1);

    if (!geometry_ok(WIDTH, DIGIT)) begin : g_bad_geometry
        $error("digit_serial_adder: WIDTH must be a multiple of DIGIT with 1 <= DIGIT <= WIDTH");
    end

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic              carry_q, carry_d;
    logic              cout_q, cout_d;
    logic              ovf_q, ovf_d;
    logic              out_valid_q, out_valid_d;
    logic              in_ready_q, in_ready_d;
    logic              busy_q, busy_d;

    logic [DIGIT-1:0]  dig_sum;
    logic              dig_cout;
    logic              dig_c_msb;

    rca_digit #(
        .DIGIT (DIGIT)
    ) u_rca_digit (
        .a     (a_q[DIGIT-1:0]),
        .b     (b_q[DIGIT-1:0]),
        .cin   (carry_q),
        .sum   (dig_sum),
        .cout  (dig_cout),
        .c_msb (dig_c_msb)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        if (flush) begin
            // Abort wins over everything; result registers keep their values.
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        // Subtraction folded into the add: a + ~b + ~cin.
                        a_d     = a;
                        b_d     = b ^ {WIDTH{sub}};
                        carry_d = cin ^ sub;
                        cnt_d   = '0;
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    // New digit enters at the MSB end; after N shifts the
                    // first digit has reached bit 0.
                    sum_d   = (WIDTH'(dig_sum) << (WIDTH - DIGIT)) | (sum_q >> DIGIT);
                    a_d     = a_q >> DIGIT;
                    b_d     = b_q >> DIGIT;
                    carry_d = dig_cout;
                    if (cnt_q == LAST) begin
                        cout_d  = dig_cout;
                        ovf_d   = dig_c_msb ^ dig_cout;
                        state_d = ST_DONE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready) state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        in_ready_d  = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_DONE);
        busy_d      = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            carry_q     <= 1'b0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            carry_q     <= carry_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_digit_serial_adder.sv
// Bench for digit_serial_adder: directed cases on an 8-bit/4-bit-digit
// instance, then randomized operations on 32-bit instances with DIGIT 1, 8
// and 32 against an arithmetic reference model.
module tb_digit_serial_adder;

    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- 8-bit instance ----------------
    logic       iv8, ir8, fl8, ov8, or8, cout8, ovf8, busy8, cin8, sub8;
    logic [7:0] a8, b8, sum8;

    digit_serial_adder #(.WIDTH(8), .DIGIT(4)) u_dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (iv8),
        .in_ready  (ir8),
        .a         (a8),
        .b         (b8),
        .cin       (cin8),
        .sub       (sub8),
        .flush     (fl8),
        .out_valid (ov8),
        .out_ready (or8),
        .sum       (sum8),
        .cout      (cout8),
        .ovf       (ovf8),
        .busy      (busy8)
    );

    // ---------------- 32-bit instances (DIGIT 1, 8, 32) ----------------
    logic        iv32 [3];
    logic        ir32 [3];
    logic        ov32 [3];
    logic        or32 [3];
    logic        co32 [3];
    logic        of32 [3];
    logic        bz32 [3];
    logic [31:0] sm32 [3];
    logic [31:0] a32, b32;
    logic        cin32, sub32, fl32;

    for (genvar g = 0; g < 3; g++) begin : g_dut32
        digit_serial_adder #(.WIDTH(32), .DIGIT(g == 0 ? 1 : (g == 1 ? 8 : 32))) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (iv32[g]),
            .in_ready  (ir32[g]),
            .a         (a32),
            .b         (b32),
            .cin       (cin32),
            .sub       (sub32),
            .flush     (fl32),
            .out_valid (ov32[g]),
            .out_ready (or32[g]),
            .sum       (sm32[g]),
            .cout      (co32[g]),
            .ovf       (of32[g]),
            .busy      (bz32[g])
        );
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on w-bit values.
    // Returns {ovf, cout, sum[63:0]}.
    function automatic logic [65:0] ref_op(input int w, input longint unsigned a,
                                           input longint unsigned b, input bit c, input bit s);
        longint unsigned mask, u, res;
        longint          sa, sb, sr, smax, smin;
        bit              co, ov;
        mask = (64'd1 << w) - 64'd1;
        sa = longint'(a);
        sb = longint'(b);
        if (a[w-1]) sa = sa - longint'(64'd1 << w);
        if (b[w-1]) sb = sb - longint'(64'd1 << w);
        smax = longint'(64'd1 << (w - 1)) - 1;
        smin = -longint'(64'd1 << (w - 1));
        if (!s) begin
            u   = a + b + 64'(c);
            res = u & mask;
            co  = (u >> w) != 0;
            sr  = sa + sb + longint'(c);
        end else begin
            res = (a - b - 64'(c)) & mask;
            co  = a >= (b + 64'(c));
            sr  = sa - sb - longint'(c);
        end
        ov = (sr > smax) || (sr < smin);
        return {ov, co, res};
    endfunction

    function automatic int n_of(input int k);
        return (k == 0) ? 32 : ((k == 1) ? 4 : 1);
    endfunction

    // One operation on the 8-bit instance; 'hold' stall cycles in DONE.
    task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input bit c, input bit s, input logic [7:0] es, input bit ec,
                       input bit eo, input int hold);
        int lat;
        lat = 0;
        while (!ir8 && lat < 50) begin @(posedge clk); #1; lat++; end
        check({tag, ".in_ready_before"}, 64'(ir8), 64'd1);
        a8 = a; b8 = b; cin8 = c; sub8 = s; iv8 = 1'b1;
        @(posedge clk); #1;
        iv8 = 1'b0;
        // Scramble inputs after acceptance; they must have no effect.
        a8 = ~a; b8 = ~b; cin8 = ~c; sub8 = ~s;
        lat = 0;
        while (!ov8 && lat < 50) begin @(posedge clk); #1; lat++; end
        check({tag, ".latency"}, 64'(lat), 64'd2);
        check({tag, ".sum"}, 64'(sum8), 64'(es));
        check({tag, ".cout"}, 64'(cout8), 64'(ec));
        check({tag, ".ovf"}, 64'(ovf8), 64'(eo));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({tag, ".hold_valid"}, 64'(ov8), 64'd1);
            check({tag, ".hold_result"}, {54'd0, ovf8, cout8, sum8}, {54'd0, eo, ec, es});
            check({tag, ".hold_in_ready"}, 64'(ir8), 64'd0);
        end
        or8 = 1'b1;
        @(posedge clk); #1;
        or8 = 1'b0;
        check({tag, ".release_valid"}, 64'(ov8), 64'd0);
        check({tag, ".release_in_ready"}, 64'(ir8), 64'd1);
    endtask

    // One random operation on 32-bit instance k with random out_ready.
    task automatic rand_op32(input int k);
        logic [65:0] e;
        int          lat;
        bit          r, done;
        a32   = $urandom;
        b32   = $urandom;
        cin32 = 1'($urandom_range(0, 1));
        sub32 = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 7))
            0: a32 = 32'h7FFF_FFFF;
            1: b32 = 32'h8000_0000;
            2: a32 = 32'hFFFF_FFFF;
            default: ;
        endcase
        e = ref_op(32, 64'(a32), 64'(b32), cin32, sub32);
        lat = 0;
        while (!ir32[k] && lat < 100) begin @(posedge clk); #1; lat++; end
        iv32[k] = 1'b1;
        @(posedge clk); #1;
        iv32[k] = 1'b0;
        a32 = $urandom; b32 = $urandom;
        lat = 0;
        while (!ov32[k] && lat < 100) begin
            or32[k] = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            lat++;
        end
        check($sformatf("r32[%0d].latency", k), 64'(lat), 64'(n_of(k)));
        check($sformatf("r32[%0d].sum", k), 64'(sm32[k]), {32'd0, e[31:0]});
        check($sformatf("r32[%0d].cout", k), 64'(co32[k]), 64'(e[64]));
        check($sformatf("r32[%0d].ovf", k), 64'(of32[k]), 64'(e[65]));
        done = 1'b0;
        lat  = 0;
        while (!done && lat < 100) begin
            r = 1'($urandom_range(0, 1));
            or32[k] = r;
            @(posedge clk); #1;
            done = r;
            lat++;
        end
        or32[k] = 1'b0;
        check($sformatf("r32[%0d].drain", k), {63'd0, ov32[k]}, 64'd0);
    endtask

    initial begin
        int  t;
        bit  seen;
        rst_n = 1'b0;
        iv8 = 1'b0; or8 = 1'b0; fl8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0;
        a32 = '0; b32 = '0; cin32 = 1'b0; sub32 = 1'b0; fl32 = 1'b0;
        for (int k = 0; k < 3; k++) begin iv32[k] = 1'b0; or32[k] = 1'b0; end

        #12;
        check("reset.in_ready", 64'(ir8), 64'd1);
        check("reset.outputs", {54'd0, busy8, ov8, ovf8, cout8, sum8}, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle.in_ready", 64'(ir8), 64'd1);
        check("idle.busy", 64'(busy8), 64'd0);

        // Directed arithmetic and backpressure
        op8("add_7f_01", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 0);
        op8("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 0);
        op8("sub_05_07", 8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0, 0);
        op8("sub_80_01", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, 0);
        op8("add_cin",   8'h0F, 8'h00, 1'b1, 1'b0, 8'h10, 1'b0, 1'b0, 0);
        op8("sub_bin",   8'h00, 8'h00, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 0);
        op8("backpress", 8'h3C, 8'h4B, 1'b1, 1'b0, 8'h88, 1'b0, 1'b1, 5);

        // Reset during RUN after the first digit
        a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; sub8 = 1'b0; iv8 = 1'b1;
        @(posedge clk); #1;
        iv8 = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("rst_mid.in_ready", 64'(ir8), 64'd1);
        check("rst_mid.outputs", {54'd0, busy8, ov8, ovf8, cout8, sum8}, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin @(posedge clk); #1; seen |= ov8; end
        check("rst_mid.no_valid", 64'(seen), 64'd0);
        op8("after_rst", 8'hA5, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 0);

        // flush during RUN
        a8 = 8'h11; b8 = 8'h22; iv8 = 1'b1;
        @(posedge clk); #1;
        iv8 = 1'b0; fl8 = 1'b1;
        @(posedge clk); #1;
        fl8 = 1'b0;
        check("flush_run.state", {61'd0, busy8, ir8, ov8}, 64'b010);
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin @(posedge clk); #1; seen |= ov8; end
        check("flush_run.no_valid", 64'(seen), 64'd0);

        // flush during DONE
        a8 = 8'h01; b8 = 8'h02; cin8 = 1'b0; sub8 = 1'b0; iv8 = 1'b1;
        @(posedge clk); #1;
        iv8 = 1'b0;
        t = 0;
        while (!ov8 && t < 20) begin @(posedge clk); #1; t++; end
        check("flush_done.reached", 64'(ov8), 64'd1);
        fl8 = 1'b1;
        @(posedge clk); #1;
        fl8 = 1'b0;
        check("flush_done.state", {61'd0, busy8, ir8, ov8}, 64'b010);

        // flush together with in_valid in IDLE: request ignored
        a8 = 8'h44; b8 = 8'h44; iv8 = 1'b1; fl8 = 1'b1;
        @(posedge clk); #1;
        iv8 = 1'b0; fl8 = 1'b0;
        check("flush_idle.state", {61'd0, busy8, ir8, ov8}, 64'b010);
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin @(posedge clk); #1; seen |= ov8 | busy8; end
        check("flush_idle.not_taken", 64'(seen), 64'd0);
        op8("after_flush", 8'hC8, 8'h64, 1'b0, 1'b1, 8'h64, 1'b1, 1'b1, 1);

        // Randomized 32-bit runs
        for (int k = 0; k < 3; k++) begin
            check($sformatf("r32[%0d].idle", k), {62'd0, ir32[k], bz32[k]}, 64'b10);
            for (int i = 0; i < 1000; i++) rand_op32(k);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
